sha256_avalon_master: RTL and testbench

- Avalon-MM initiator that drives the SHA-256 core's Avalon slave port from the host side.
- Transfers a 16-word message block from a local buffer into the core's message RAM, then writes the start command.
- Polls the status register until done, then reads the 8 digest words into a local digest buffer.
- Used in the board-level test harness and by the on-chip controller in place of a soft CPU.

---
 rtl/sha256_avalon_pkg.sv | 21 ++
 rtl/sha256_av_xfer.sv | 67 ++++++
 rtl/sha256_avalon_master.sv | 183 ++++++++++++++++++
 tb/tb_sha256_avalon_master.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_avalon_pkg.sv
// Shared encodings and default address map for the SHA-256 Avalon initiator.
package sha256_avalon_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_CMD   = 3'd2;
  localparam state_t ST_POLL  = 3'd3;
  localparam state_t ST_FETCH = 3'd4;
  localparam state_t ST_FIN   = 3'd5;
  localparam state_t ST_GAP   = 3'd6;

  localparam logic [11:0] MSG_BASE  = 12'h000;
  localparam logic [11:0] DIG_BASE  = 12'h010;
  localparam logic [11:0] CMD_ADDR  = 12'hFC0;
  localparam logic [31:0] CMD_START = 32'h0000_0001;

  localparam int STATUS_DONE_BIT = 0;

endpackage

// File: rtl/sha256_av_xfer.sv
// Single Avalon-MM transfer engine: registers one request, holds it through
// slave stalls, acknowledges in the completion cycle, then forces one idle GAP cycle.
module sha256_av_xfer
  import sha256_avalon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rd_nwr,
  input  logic [13:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [1:0]  resp,
  output logic [13:0] av_address,
  output logic        av_read,
  output logic        av_write,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest_n,
  input  logic [1:0]  av_response
);

  // Reuses the shared IDLE/GAP encodings; 3'd7 is free for an outstanding transfer.
  localparam state_t XF_ACTIVE = 3'd7;

  state_t phase;

  assign ack   = (phase == XF_ACTIVE) && av_waitrequest_n;
  assign rdata = av_readdata;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase        <= ST_IDLE;
      av_address   <= '0;
      av_read      <= 1'b0;
      av_write     <= 1'b0;
      av_writedata <= '0;
      resp         <= '0;
    end else begin
      case (phase)
        ST_IDLE, ST_GAP: begin
          if (req) begin
            phase        <= XF_ACTIVE;
            av_address   <= addr;
            av_read      <= rd_nwr;
            av_write     <= !rd_nwr;
            av_writedata <= wdata;
          end else begin
            phase <= ST_IDLE;
          end
        end
        XF_ACTIVE: begin
          if (av_waitrequest_n) begin
            phase    <= ST_GAP;
            av_read  <= 1'b0;
            av_write <= 1'b0;
            resp     <= av_response;
          end
        end
        default: phase <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sha256_avalon_master.sv
// Sequencer that loads a message block into the SHA-256 core, starts it, polls
// for done and fetches the digest. Optional bus lock: define SHA_LOCK_EN.
module sha256_avalon_master #(
  parameter logic [11:0] MSG_BASE   = sha256_avalon_pkg::MSG_BASE,
  parameter logic [11:0] DIG_BASE   = sha256_avalon_pkg::DIG_BASE,
  parameter logic [11:0] CMD_ADDR   = sha256_avalon_pkg::CMD_ADDR,
  parameter logic [31:0] CMD_START  = sha256_avalon_pkg::CMD_START,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        msg_wr_en,
  input  logic [3:0]  msg_wr_addr,
  input  logic [31:0] msg_wr_data,
  input  logic [2:0]  dig_rd_addr,
  output logic [31:0] dig_rd_data,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [13:0] av_address,
  output logic        av_read,
  output logic        av_write,
  output logic [31:0] av_writedata,
  output logic        av_lock,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest_n,
  input  logic [1:0]  av_response
);
  import sha256_avalon_pkg::*;

  localparam int PW = $clog2(POLL_LIMIT + 1);

  state_t        state;
  logic [3:0]    idx;
  logic [PW-1:0] poll_cnt;
  logic [31:0]   msg [16];
  logic [31:0]   dig [8];

  logic          req;
  logic          rd_nwr;
  logic [13:0]   addr;
  logic [31:0]   wdata;
  logic          ack;
  logic [31:0]   rdata;
  logic [1:0]    resp;
  logic          poll_last;
  logic          seq_end;

  // Slave response is recorded by the engine but has no effect on sequencing.
  logic unused_resp;
  assign unused_resp = ^resp;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req    = 1'b0;
    rd_nwr = 1'b0;
    addr   = '0;
    wdata  = '0;
    case (state)
      ST_LOAD: begin
        req   = 1'b1;
        addr  = {2'b00, MSG_BASE + {8'h00, idx}};
        wdata = msg[idx];
      end
      ST_CMD: begin
        req   = 1'b1;
        addr  = {2'b00, CMD_ADDR};
        wdata = CMD_START;
      end
      ST_POLL: begin
        req    = 1'b1;
        rd_nwr = 1'b1;
        addr   = {2'b00, CMD_ADDR};
      end
      ST_FETCH: begin
        req    = 1'b1;
        rd_nwr = 1'b1;
        addr   = {2'b00, DIG_BASE + {9'h000, idx[2:0]}};
      end
      default: ;
    endcase
  end

  assign poll_last = (poll_cnt == PW'(POLL_LIMIT - 1));
  assign seq_end   = ack && (((state == ST_POLL) && !rdata[STATUS_DONE_BIT] && poll_last) ||
                             ((state == ST_FETCH) && (idx == 4'd7)));

  sha256_av_xfer u_xfer (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .rd_nwr           (rd_nwr),
    .addr             (addr),
    .wdata            (wdata),
    .ack              (ack),
    .rdata            (rdata),
    .resp             (resp),
    .av_address       (av_address),
    .av_read          (av_read),
    .av_write         (av_write),
    .av_writedata     (av_writedata),
    .av_readdata      (av_readdata),
    .av_waitrequest_n (av_waitrequest_n),
    .av_response      (av_response)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      poll_cnt    <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 8; i++) dig[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_LOAD;
            idx         <= '0;
            timeout_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ack) begin
            if (idx == 4'd15) state <= ST_CMD;
            idx <= idx + 4'd1;
          end
        end
        ST_CMD: begin
          if (ack) begin
            state    <= ST_POLL;
            poll_cnt <= '0;
          end
        end
        ST_POLL: begin
          if (ack) begin
            if (rdata[STATUS_DONE_BIT]) begin
              state <= ST_FETCH;
              idx   <= '0;
            end else if (poll_last) begin
              timeout_err <= 1'b1;
              state       <= ST_FIN;
            end else begin
              poll_cnt <= poll_cnt + PW'(1);
            end
          end
        end
        ST_FETCH: begin
          if (ack) begin
            dig[idx[2:0]] <= rdata;
            if (idx == 4'd7) state <= ST_FIN;
            idx <= idx + 4'd1;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the message buffer is plain storage with no reset, so it can map to RAM.
  always_ff @(posedge clk) begin
    if (msg_wr_en) msg[msg_wr_addr] <= msg_wr_data;
  end

  assign dig_rd_data = dig[dig_rd_addr];
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_FIN);

`ifdef SHA_LOCK_EN
  // Rises with the first LOAD write and drops on the edge that enters FIN.
  logic lock_q;
  always_ff @(posedge clk) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= (state inside {ST_LOAD, ST_CMD, ST_POLL, ST_FETCH}) && !seq_end;
  end
  assign av_lock = lock_q;
`else
  assign av_lock = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_avalon_master.sv
// Directed bench: behavioural core slave with optional stalls plus a bus protocol monitor.
module tb_sha256_avalon_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        msg_wr_en = 1'b0;
  logic [3:0]  msg_wr_addr = '0;
  logic [31:0] msg_wr_data = '0;
  logic [2:0]  dig_rd_addr = '0;
  logic [31:0] dig_rd_data;
  logic        busy, done, timeout_err;
  logic [13:0] av_address;
  logic        av_read, av_write, av_lock;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata = '0;
  logic        av_waitrequest_n = 1'b1;
  logic [1:0]  av_response = 2'b00;

  always #5 clk = ~clk;

  sha256_avalon_master #(.POLL_LIMIT(8)) dut (
    .clk (clk), .reset (reset), .start (start),
    .msg_wr_en (msg_wr_en), .msg_wr_addr (msg_wr_addr), .msg_wr_data (msg_wr_data),
    .dig_rd_addr (dig_rd_addr), .dig_rd_data (dig_rd_data),
    .busy (busy), .done (done), .timeout_err (timeout_err),
    .av_address (av_address), .av_read (av_read), .av_write (av_write),
    .av_writedata (av_writedata), .av_lock (av_lock), .av_readdata (av_readdata),
    .av_waitrequest_n (av_waitrequest_n), .av_response (av_response)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SHA-256("abc") as returned by the core's digest words.
  logic [31:0] digest_rom [8] = '{32'hBA78_16BF, 32'h8F01_CFEA, 32'h4141_40DE, 32'h5DAE_2223,
                                  32'hB003_61A3, 32'h9617_7A9C, 32'hB410_FF61, 32'hF200_15AD};
  logic [31:0] msg_exp [16];

  int stall_cycles = 0;
  int done_after   = 3;
  int stall_cnt    = 0;
  logic [13:0] wr_addr_log [32];
  logic [31:0] wr_data_log [32];
  int wr_n, rd_n, poll_n, dig_rd_n, done_n, xfer_n, stall_n;
  int b2b_err, gap_err, stable_err, both_err, idle_run;
  int lock_err = 0;
  logic        prev_strobe = 1'b0, prev_cmp = 1'b0, p_read = 1'b0;
  logic [13:0] p_addr = '0;
  logic [31:0] p_wdata = '0;

  // Slave model and protocol monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    logic strobe, cmp;
    strobe = av_read | av_write;
    if (av_read && av_write) both_err++;
    if (strobe && prev_cmp) b2b_err++;
    if (strobe && prev_strobe && !prev_cmp &&
        (av_address !== p_addr || av_writedata !== p_wdata || av_read !== p_read)) stable_err++;
    if (strobe && !prev_strobe) begin
      if (xfer_n > 0 && idle_run != 1) gap_err++;
      xfer_n++;
    end
    idle_run = strobe ? 0 : idle_run + 1;
    if (done) done_n++;
`ifdef SHA_LOCK_EN
    if ((strobe && !av_lock) || (done && av_lock) || (!busy && av_lock) ||
        (busy && !done && xfer_n > 0 && !av_lock)) lock_err++;
`else
    if (av_lock) lock_err++;
`endif
    if (strobe && stall_cnt < stall_cycles) begin
      av_waitrequest_n = 1'b0;
      stall_cnt++;
      stall_n++;
    end else begin
      av_waitrequest_n = 1'b1;
      stall_cnt = 0;
    end
    cmp = strobe && av_waitrequest_n;
    av_readdata = 32'hDEAD_BEEF;
    if (cmp && av_write) begin
      if (wr_n < 32) begin
        wr_addr_log[wr_n] = av_address;
        wr_data_log[wr_n] = av_writedata;
      end
      wr_n++;
    end
    if (cmp && av_read) begin
      rd_n++;
      if (av_address == 14'h0FC0) begin
        av_readdata = 32'hA5A5_A5A4 | {31'd0, (done_after != 0 && poll_n + 1 >= done_after)};
        poll_n++;
      end else if (av_address >= 14'h0010 && av_address < 14'h0018) begin
        av_readdata = digest_rom[av_address[2:0]];
        dig_rd_n++;
      end
    end
    prev_strobe = strobe;
    prev_cmp    = cmp;
    p_addr      = av_address;
    p_wdata     = av_writedata;
    p_read      = av_read;
  end

  task automatic clear_counts();
    wr_n = 0; rd_n = 0; poll_n = 0; dig_rd_n = 0; done_n = 0; xfer_n = 0; stall_n = 0;
    b2b_err = 0; gap_err = 0; stable_err = 0; both_err = 0;
  endtask

  task automatic load_msg();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      msg_wr_en   = 1'b1;
      msg_wr_addr = 4'(i);
      msg_wr_data = msg_exp[i];
    end
    @(negedge clk);
    msg_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_n != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_dig_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      dig_rd_addr = 3'(i);
      #1 check(tag, dig_rd_data, 32'h0);
    end
  endtask

  initial begin
    int n;
    clear_counts();
    idle_run = 0;

    // Reset held across two edges
    repeat (2) @(negedge clk);
    check("rst_read", av_read, 1'b0);
    check("rst_write", av_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tmo", timeout_err, 1'b0);
    check("rst_lock", av_lock, 1'b0);
    check_dig_zero("rst_dig");
    reset = 1'b0;

    // Zero-wait slave, padded "abc" block
    for (int i = 0; i < 16; i++) msg_exp[i] = 32'h0;
    msg_exp[0]  = 32'h6162_6380;
    msg_exp[15] = 32'h0000_0018;
    load_msg();
    stall_cycles = 0; done_after = 3;
    clear_counts();
    pulse_start();
    check("busy_after_start", busy, 1'b1);
    wait_done("abc", 500);
    check("abc_wr_n", wr_n, 17);
    for (int i = 0; i < 16; i++) begin
      check("abc_wr_addr", wr_addr_log[i], 32'(i));
      check("abc_wr_data", wr_data_log[i], msg_exp[i]);
    end
    check("abc_cmd_addr", wr_addr_log[16], 32'h0FC0);
    check("abc_cmd_data", wr_data_log[16], 32'h1);
    check("abc_polls", poll_n, 3);
    check("abc_dig_reads", dig_rd_n, 8);
    check("abc_done_n", done_n, 1);
    check("abc_busy", busy, 1'b0);
    check("abc_tmo", timeout_err, 1'b0);
    dig_rd_addr = 3'd0;
    #1 check("abc_dig0", dig_rd_data, 32'hBA78_16BF);
    dig_rd_addr = 3'd7;
    #1 check("abc_dig7", dig_rd_data, 32'hF200_15AD);
    for (int i = 1; i < 7; i++) begin
      dig_rd_addr = 3'(i);
      #1 check("abc_dig", dig_rd_data, digest_rom[i]);
    end
    check("abc_gap", gap_err, 0);
    check("abc_b2b", b2b_err, 0);

    // Stalling slave plus a second start pulsed mid-LOAD
    for (int i = 0; i < 16; i++) msg_exp[i] = 32'hC0DE_0000 | 32'(i);
    load_msg();
    stall_cycles = 5;
    clear_counts();
    pulse_start();
    n = 0;
    while (wr_n < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("stall_mid_load", 32'(wr_n >= 5), 32'd1);
    pulse_start();
    wait_done("stall", 3000);
    check("stall_wr_n", wr_n, 17);
    check("stall_wr7", wr_data_log[7], 32'hC0DE_0007);
    check("stall_rd_n", rd_n, 11);
    check("stall_one_cmp", wr_n + rd_n, xfer_n);
    check("stall_cycles", stall_n, 5 * 28);
    check("stall_stable", stable_err, 0);
    check("stall_gap", gap_err, 0);
    check("stall_b2b", b2b_err, 0);
    check("stall_done_n", done_n, 1);

    // Status never reports done
    stall_cycles = 0; done_after = 0;
    clear_counts();
    pulse_start();
    wait_done("tmo", 500);
    check("tmo_polls", poll_n, 8);
    check("tmo_flag", timeout_err, 1'b1);
    check("tmo_done_n", done_n, 1);
    check("tmo_dig_reads", dig_rd_n, 0);
    done_after = 3;
    clear_counts();
    pulse_start();
    check("tmo_cleared", timeout_err, 1'b0);
    wait_done("after_tmo", 500);
    check("after_tmo_flag", timeout_err, 1'b0);
    check("after_tmo_done_n", done_n, 1);

    // Reset during FETCH idx = 3
    clear_counts();
    pulse_start();
    n = 0;
    while (!(av_read && av_address == 14'h0013) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("fetch3_reached", 32'(av_read && av_address == 14'h0013), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_read", av_read, 1'b0);
    check("mid_rst_write", av_write, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check_dig_zero("mid_rst_dig");
    reset = 1'b0;
    clear_counts();
    pulse_start();
    wait_done("post_rst", 500);
    check("post_rst_dig_reads", dig_rd_n, 8);
    check("post_rst_done_n", done_n, 1);
    dig_rd_addr = 3'd7;
    #1 check("post_rst_dig7", dig_rd_data, 32'hF200_15AD);

    check("both_strobes", both_err, 0);
    check("lock", lock_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
